// File: rtl/clock_works.sv
// clock_works: clock gearbox and reset generator between the board pins and
// the internal logic.
//
// Divides the board clock CLK by 2^SLOW to produce the internal clock clk.
// SLOW = 0 passes CLK straight through. Also produces the internal
// active-low reset resetn. After power-up, or after RESET is pulled low,
// resetn stays low for 2^RESET_WIDTH - 1 rising edges of clk. This works
// around the iCE40 start-up problem.
//
// Parameters:
//   SLOW        - divide exponent; clk = CLK / 2^SLOW (0 = bypass)
//   RESET_WIDTH - width of the release counter
// Ports:
//   CLK    in  board clock, the only clock
//   RESET  in  board reset button, asynchronous, active-low
//   clk    out divided internal clock (held at 0 while RESET is low
//              in divider mode)
//   resetn out internal reset, active-low; asserts asynchronously and
//              releases on a clk rising edge
//
// All registers rely on the device's power-up initialisation to 0. That
// has the same effect as a RESET pulse.
module clock_works #(
    parameter int SLOW        = 0,
    parameter int RESET_WIDTH = 16
) (
    input  logic CLK,
    input  logic RESET,
    output logic clk,
    output logic resetn
);

    logic [RESET_WIDTH-1:0] rst_cnt;

    generate
        if (SLOW == 0) begin : g_bypass
            assign clk = CLK;
        end else begin : g_div
            logic [SLOW-1:0] div_cnt;

            // Free-running counter. The MSB is a 50 % duty clock. Clearing
            // the counter on RESET restarts the clk phase from 0.
            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end

            assign clk = div_cnt[SLOW-1];
        end
    endgenerate

    // The counter counts up while resetn is low and stops at all-ones.
    // resetn is derived from the registered count, so it only rises on a clk
    // edge. The asynchronous clear drops it immediately.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            rst_cnt <= '0;
        end else if (!resetn) begin
            rst_cnt <= rst_cnt + 1'b1;
        end
    end

    assign resetn = &rst_cnt;

endmodule

// File: tb/tb_clock_works.sv
module tb_clock_works;

    logic CLK = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic rst_c = 1'b1;
    logic clk_a, clk_b, clk_c;
    logic resetn_a, resetn_b, resetn_c;

    int checks = 0;
    int failures = 0;

    // CLK rising edges seen with RESET high since the last RESET assertion
    int e_a = 0;
    int e_b = 0;
    int e_c = 0;

    clock_works #(.SLOW(3), .RESET_WIDTH(4)) dut_a (
        .CLK(CLK), .RESET(rst_a), .clk(clk_a), .resetn(resetn_a)
    );
    clock_works #(.SLOW(0), .RESET_WIDTH(2)) dut_b (
        .CLK(CLK), .RESET(rst_b), .clk(clk_b), .resetn(resetn_b)
    );
    clock_works #(.SLOW(2), .RESET_WIDTH(3)) dut_c (
        .CLK(CLK), .RESET(rst_c), .clk(clk_c), .resetn(resetn_c)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge rst_a) if (!rst_a) e_a = 0; else e_a = e_a + 1;
    always @(posedge CLK or negedge rst_b) if (!rst_b) e_b = 0; else e_b = e_b + 1;
    always @(posedge CLK or negedge rst_c) if (!rst_c) e_c = 0; else e_c = e_c + 1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Number of clk rising edges after e CLK edges since release.
    function automatic int model_rises(input int slow, input int e);
        if (slow == 0) return e;
        return (e + (1 << (slow - 1))) / (1 << slow);
    endfunction

    function automatic int model_clk(input int slow, input int e, input int level);
        if (slow == 0) return level;
        return ((e % (1 << slow)) >= (1 << (slow - 1))) ? 1 : 0;
    endfunction

    function automatic int model_cnt(input int slow, input int rw, input int e);
        int r;
        int top;
        r = model_rises(slow, e);
        top = (1 << rw) - 1;
        return (r > top) ? top : r;
    endfunction

    function automatic int model_resetn(input int slow, input int rw, input int e);
        return (model_cnt(slow, rw, e) == (1 << rw) - 1) ? 1 : 0;
    endfunction

    task automatic check_all(input int level);
        chk("a_clk",    int'(clk_a),         model_clk(3, e_a, level));
        chk("a_resetn", int'(resetn_a),      model_resetn(3, 4, e_a));
        chk("a_rstcnt", int'(dut_a.rst_cnt), model_cnt(3, 4, e_a));
        chk("b_clk",    int'(clk_b),         model_clk(0, e_b, level));
        chk("b_resetn", int'(resetn_b),      model_resetn(0, 2, e_b));
        chk("b_rstcnt", int'(dut_b.rst_cnt), model_cnt(0, 2, e_b));
        chk("c_clk",    int'(clk_c),         model_clk(2, e_c, level));
        chk("c_resetn", int'(resetn_c),      model_resetn(2, 3, e_c));
        chk("c_rstcnt", int'(dut_c.rst_cnt), model_cnt(2, 3, e_c));
    endtask

    always @(posedge CLK) begin
        #1;
        check_all(1);
    end

    always @(negedge CLK) begin
        #1;
        check_all(0);
    end

    task automatic check_async();
        chk("async_a_resetn", int'(resetn_a), 0);
        chk("async_a_clk",    int'(clk_a),    0);
        chk("async_b_resetn", int'(resetn_b), 0);
        chk("async_c_resetn", int'(resetn_c), 0);
        chk("async_c_clk",    int'(clk_c),    0);
    endtask

    initial begin
        int lat;
        int mode;
        int n;

        // Power-up: dut_c never sees RESET; dut_a/dut_b hold RESET low 5 cycles
        chk("pwr_a_resetn", int'(resetn_a), 0);
        chk("pwr_c_resetn", int'(resetn_c), 0);
        repeat (5) @(negedge CLK);
        #3;
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Release latency on dut_a in CLK edges, bounded
        lat = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge CLK);
            #2;
            if (resetn_a) begin
                lat = i;
                break;
            end
        end
        chk("a_release_latency", lat, 116);
        repeat (200) @(negedge CLK);
        chk("a_resetn_hold", int'(resetn_a), 1);

        // Random RESET pulses (glitches and multi-cycle) with random run lengths
        for (int seg = 0; seg < 10; seg++) begin
            mode = (seg == 0) ? 0 : int'($urandom_range(0, 1));
            if (mode == 0) begin
                @(posedge CLK);
                #2;
                rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
                #1;
                check_async();
                #1;
                rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
            end else begin
                n = int'($urandom_range(1, 6));
                @(negedge CLK);
                #3;
                rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
                #1;
                check_async();
                repeat (n) @(negedge CLK);
                #3;
                rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
            end
            n = (seg == 9) ? 400 : int'($urandom_range(20, 300));
            repeat (n) @(negedge CLK);
        end

        // Saturation: well past release the counters stay all-ones
        chk("a_sat_cnt", int'(dut_a.rst_cnt), 15);
        chk("a_sat_resetn", int'(resetn_a), 1);
        chk("c_sat_cnt", int'(dut_c.rst_cnt), 7);

        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
